// File: rtl/tcdm_apb_bridge_multi.sv
// TCDM slave port to multi-slave APB4 bridge.
// Address-decoded fan-out, one transaction in flight, wait-state timeout.
module tcdm_apb_bridge_multi #(
  parameter int NR_APB_SLAVES = 4,
  parameter int NR_RULES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hBADACCE5,
  parameter int IDX_W = (NR_APB_SLAVES > 1) ? $clog2(NR_APB_SLAVES) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic gnt_o,
  output logic r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic r_opc_o,
  input  logic [NR_RULES*ADDR_WIDTH-1:0] rule_start_i,
  input  logic [NR_RULES*ADDR_WIDTH-1:0] rule_end_i,
  input  logic [NR_RULES*IDX_W-1:0] rule_idx_i,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic pwrite_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [NR_APB_SLAVES-1:0] psel_o,
  output logic penable_o,
  input  logic [NR_APB_SLAVES-1:0] pready_i,
  input  logic [NR_APB_SLAVES*DATA_WIDTH-1:0] prdata_i,
  input  logic [NR_APB_SLAVES-1:0] pslverr_i
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0] strb_q;
  logic wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic opc_q;

  logic found, hit;
  logic [IDX_W-1:0] dec_idx;
  logic sel_ready, sel_err, timeout;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // Lowest-numbered matching rule decides; an out-of-range target is a miss.
  always_comb begin
    found = 1'b0;
    hit = 1'b0;
    dec_idx = '0;
    for (int r = 0; r < NR_RULES; r++) begin
      if (!found &&
          add_i >= rule_start_i[r*ADDR_WIDTH +: ADDR_WIDTH] &&
          add_i < rule_end_i[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
        found = 1'b1;
        dec_idx = rule_idx_i[r*IDX_W +: IDX_W];
      end
    end
    for (int s = 0; s < NR_APB_SLAVES; s++) begin
      if (found && dec_idx == IDX_W'(s)) hit = 1'b1;
    end
  end

  always_comb begin
    psel_o = '0;
    sel_ready = 1'b0;
    sel_err = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < NR_APB_SLAVES; s++) begin
      if (idx_q == IDX_W'(s)) begin
        sel_ready = pready_i[s];
        sel_err = pslverr_i[s];
        sel_rdata = prdata_i[s*DATA_WIDTH +: DATA_WIDTH];
        psel_o[s] = (state_q == SETUP) || (state_q == ACCESS);
      end
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_i) state_d = hit ? SETUP : RESP;
      SETUP: state_d = ACCESS;
      ACCESS: if (sel_ready || timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      opc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q <= add_i;
            wr_q <= ~wen_i;
            wdata_q <= wdata_i;
            strb_q <= wen_i ? '0 : be_i;
            idx_q <= dec_idx;
            if (!hit) begin
              rdata_q <= wen_i ? ERR_RDATA : '0;
              opc_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            rdata_q <= wr_q ? '0 : sel_rdata;
            opc_q <= sel_err;
            cnt_q <= '0;
          end else if (timeout) begin
            rdata_q <= wr_q ? '0 : ERR_RDATA;
            opc_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt_o = (state_q == IDLE) && req_i && !rst_i;
  assign penable_o = (state_q == ACCESS);
  assign r_valid_o = (state_q == RESP);
  assign r_rdata_o = rdata_q;
  assign r_opc_o = opc_q;
  assign paddr_o = addr_q;
  assign pwdata_o = wdata_q;
  assign pwrite_o = wr_q;
  assign pstrb_o = strb_q;

endmodule

// File: tb/tb_tcdm_apb_bridge_multi.sv
// Scoreboard bench for tcdm_apb_bridge_multi.
// Directed TCDM requests; a negedge monitor checks APB phases and responses.
module tb_tcdm_apb_bridge_multi;

  logic clk = 1'b0;
  logic rst;
  logic req, wen, gnt, rvalid, ropc, pwrite, penable;
  logic [31:0] addr, wdata, rdata, paddr, pwdata;
  logic [3:0] be, pstrb, psel, pready, pslverr, rdy;
  logic [127:0] rule_start, rule_end, prdata;
  logic [7:0] rule_idx;

  always #5 clk = ~clk;

  tcdm_apb_bridge_multi #(
    .NR_APB_SLAVES(4),
    .NR_RULES(4),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA(32'hBADACCE5)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .add_i(addr),
    .wen_i(wen),
    .wdata_i(wdata),
    .be_i(be),
    .gnt_o(gnt),
    .r_valid_o(rvalid),
    .r_rdata_o(rdata),
    .r_opc_o(ropc),
    .rule_start_i(rule_start),
    .rule_end_i(rule_end),
    .rule_idx_i(rule_idx),
    .paddr_o(paddr),
    .pwdata_o(pwdata),
    .pwrite_o(pwrite),
    .pstrb_o(pstrb),
    .psel_o(psel),
    .penable_o(penable),
    .pready_i(pready),
    .prdata_i(prdata),
    .pslverr_i(pslverr)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Slave model: selected slave answers after `stall` wait states.
  int stall = 0;
  int acc_cnt = 0;
  logic noise_en = 1'b0;
  logic tog = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tog <= ~tog;
    if (penable && (pready & psel) == 4'b0) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    rdy = (penable && acc_cnt >= stall) ? psel : 4'b0;
    pready = rdy | ((noise_en && tog) ? 4'b1000 : 4'b0000);
  end

  typedef struct {
    logic [31:0] rd;
    logic opc;
    int at;
    int pc;
  } exp_t;

  exp_t q[$];
  logic [3:0] exp_psel, exp_strb;
  logic [31:0] exp_addr, exp_wdata, hold;
  logic exp_write;
  int pcount = 0;

  always @(negedge clk) begin
    if (rst) begin
      pcount = 0;
      hold = 32'h0;
    end else begin
      if (psel != 4'b0) begin
        chk("penable", penable, pcount != 0);
        pcount++;
        chk("psel", psel, exp_psel);
        chk("paddr", paddr, exp_addr);
        chk("pwrite", pwrite, exp_write);
        chk("pstrb", pstrb, exp_strb);
        chk("pwdata", pwdata, exp_wdata);
      end else begin
        chk("penable_idle", penable, 0);
      end
      if (rvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", rvalid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata", rdata, e.rd);
          chk("opc", ropc, e.opc);
          chk("resp_cycle", cyc, e.at);
          chk("psel_cycles", pcount, e.pc);
          hold = e.rd;
          pcount = 0;
        end
      end else begin
        chk("rdata_hold", rdata, hold);
      end
    end
  end

  task automatic set_rule(input int r, input logic [31:0] s,
                          input logic [31:0] e, input logic [1:0] ix);
    rule_start[r*32 +: 32] = s;
    rule_end[r*32 +: 32] = e;
    rule_idx[r*2 +: 2] = ix;
  endtask

  task automatic issue(input logic [31:0] a, input logic rd,
                       input logic [31:0] wd, input logic [3:0] b,
                       input logic [3:0] ps, input logic [31:0] er,
                       input logic eo, input int lat, input int pc);
    exp_psel = ps;
    exp_addr = a;
    exp_write = ~rd;
    exp_strb = rd ? 4'b0 : b;
    exp_wdata = wd;
    req = 1'b1;
    addr = a;
    wen = rd;
    wdata = wd;
    be = b;
    @(negedge clk);
    chk("gnt", gnt, 1);
    if (gnt) q.push_back('{er, eo, cyc + lat, pc});
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_pending", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 1'b1;
    addr = 32'h0;
    wen = 1'b1;
    wdata = 32'h0;
    be = 4'h0;
    pslverr = 4'b0;
    rule_start = '0;
    rule_end = '0;
    rule_idx = '0;
    prdata = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'hA0A0_A0A0};
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_ctrl", {psel, penable, pwrite, rvalid, ropc}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_rdata", rdata, 0);
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    set_rule(0, 32'h1A10_0000, 32'h1A11_0000, 2'd2);
    issue(32'h1A10_0004, 1, 32'hDEAD_0000, 4'hF, 4'b0100,
          32'h1234_5678, 0, 3, 2);
    wait_done();
    issue(32'h1A10_0000, 1, 32'h0, 4'hF, 4'b0100, 32'h1234_5678, 0, 3, 2);
    wait_done();

    stall = 3;
    issue(32'h1A10_0008, 0, 32'hCAFE_F00D, 4'b0011, 4'b0100, 32'h0, 0, 6, 5);
    wait_done();
    stall = 0;

    issue(32'h0000_0000, 1, 32'h0, 4'hF, 4'b0000, 32'hBADA_CCE5, 1, 1, 0);
    wait_done();
    issue(32'h1A11_0000, 0, 32'h5555, 4'hF, 4'b0000, 32'h0, 1, 1, 0);
    wait_done();

    stall = 100;
    issue(32'h1A10_0010, 1, 32'h0, 4'hF, 4'b0100, 32'hBADA_CCE5, 1, 6, 5);
    wait_done();
    issue(32'h1A10_0014, 0, 32'h77, 4'b1000, 4'b0100, 32'h0, 1, 6, 5);
    wait_done();
    stall = 0;

    set_rule(0, 32'h1A20_0000, 32'h1A21_0000, 2'd1);
    set_rule(1, 32'h1A20_0000, 32'h1A21_0000, 2'd3);
    pslverr = 4'b1010;
    noise_en = 1'b1;
    stall = 2;
    issue(32'h1A20_0040, 1, 32'h0, 4'hF, 4'b0010, 32'h1111_1111, 1, 5, 4);
    wait_done();
    pslverr = 4'b1000;
    issue(32'h1A20_0044, 0, 32'h0BAD_BEEF, 4'b0110, 4'b0010, 32'h0, 0, 5, 4);
    wait_done();
    issue(32'h1A20_0048, 1, 32'h0, 4'hF, 4'b0010, 32'h1111_1111, 0, 5, 4);
    wait_done();
    noise_en = 1'b0;
    pslverr = 4'b0;

    stall = 100;
    exp_psel = 4'b0010;
    exp_addr = 32'h1A20_0000;
    exp_write = 1'b0;
    exp_strb = 4'b0;
    exp_wdata = 32'h0;
    req = 1'b1;
    addr = 32'h1A20_0000;
    wen = 1'b1;
    wdata = 32'h0;
    be = 4'hF;
    @(negedge clk);
    chk("gnt_abort", gnt, 1);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_ctrl", {gnt, psel, penable, pwrite, rvalid, ropc}, 0);
    chk("abort_paddr", paddr, 0);
    chk("abort_pstrb", pstrb, 0);
    chk("abort_rdata", rdata, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 0;
    repeat (3) @(posedge clk);
    #1;
    issue(32'h1A20_0000, 1, 32'h0, 4'hF, 4'b0010, 32'h1111_1111, 0, 3, 2);
    wait_done();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
